decim_output_serializer: RTL and testbench
==========================================

Name: decim_output_serializer

Overview:
- Downstream stage of the 16-bit CIC/incremental decimation filter.
- Captures each decimated word on a valid strobe and buffers it in a small FIFO.
- Shifts words out MSB-first on a 3-wire serial link (sclk, sdata, fsync), which frees the 16 output pins currently used for the parallel word.
- Reports FIFO fill level and a sticky overflow flag.

Parameters:
- DATA_BITS, 16: width of the decimated word and the serial frame length in bits.
- FIFO_DEPTH, 4: number of buffered words; must be a power of 2 and at least 2.
- DIV, 1: clk cycles per sclk half-period; must be at least 1. One bit period is 2*DIV clk cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- din  in  DATA_BITS  decimated word from the filter.
- din_valid  in  1  single-cycle strobe; din is valid in the same cycle.
- enable  in  1  permits new frames to start.
- clear_ovf  in  1  synchronous clear of the overflow flag.
- sclk  out  1  serial clock; idles low.
- sdata  out  1  serial data; changes only while sclk is low.
- fsync  out  1  high for the whole of bit 0 (MSB) of each frame.
- busy  out  1  high in states LOAD, SHIFT and GAP.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently stored in the FIFO.
- overflow  out  1  sticky; set when a word is dropped.

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-high. All outputs are 0, the FIFO is empty, pointers are 0 and the FSM is in IDLE. Reset mid-frame aborts the frame immediately and discards all buffered data.
- FIFO write:
  - When din_valid=1, din is written at the write pointer if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set to 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count is registered and updates one cycle after the write or pop: +1, -1, or unchanged when both happen together.
- Overflow: if clear_ovf=1 and a drop occur in the same cycle, set wins. Otherwise clear_ovf=1 drives overflow to 0 on the next edge.
- FSM state IDLE:
  - sclk=0, sdata=0, fsync=0, busy=0.
  - If enable=1 and fifo_count>0, go to LOAD.
- FSM state LOAD (1 cycle):
  - Pop the FIFO head into the shift register.
  - Drive sdata=head[DATA_BITS-1] and fsync=1.
  - Clear div_cnt and bit_cnt, then go to SHIFT.
  - The word popped is the one present at the head at that edge, so FIFO order is preserved.
- FSM state SHIFT:
  - div_cnt increments every cycle.
  - When div_cnt==DIV-1, div_cnt returns to 0 and sclk toggles.
  - 0->1 (rising edge): no other change. The receiver samples sdata on this edge.
  - 1->0 (falling edge): bit_cnt increments.
  - If bit_cnt was DATA_BITS-1, go to GAP.
  - Otherwise shift left, drive the next bit on sdata, and set fsync=0.
- FSM state GAP:
  - sclk=0, sdata=0, fsync=0.
  - Hold for 2*DIV cycles, then go to IDLE.
  - IDLE may re-enter LOAD on the very next cycle.
- Frame timing:
  - A frame is 1 + 2*DIV*DATA_BITS + 2*DIV clk cycles; with the defaults this is 35.
  - busy is 1 for exactly this many cycles.
- enable=0 mid-frame: the current frame completes normally. No new LOAD starts while enable=0, and the FIFO keeps accepting writes.
- Rate limit: sustained throughput is one word per frame length. Samples arriving faster fill the FIFO and then set overflow. With the filter at M=16 this is a known limit, and integrators must pick DIV and M so that samples arrive no faster than one per frame.
- Arithmetic: all counters are unsigned and sized with $clog2. There is no data arithmetic; din passes through bit-exact.

Test Plan:
1. Single word, defaults, enable=1: din=16'hA5C3 with one din_valid pulse.
   - Bits sampled on the 16 sclk rising edges are 1010_0101_1100_0011.
   - fsync is high only during the first bit.
   - busy is high for 35 cycles; sclk and sdata are 0 afterwards.
2. Burst with enable=0: 5 back-to-back valids 0x0001..0x0005.
   - fifo_count=4 and overflow=1; 0x0005 is dropped.
   - Then raise enable: frames 0x0001..0x0004 emerge in order, separated by the 2-cycle GAP, and fifo_count reaches 0.
3. Full FIFO with simultaneous pop and write: fill to 4, enable=1, then din_valid=1 with 0x00FF in the LOAD cycle.
   - The write is accepted, overflow stays 0, and fifo_count stays 4.
   - 0x00FF is emitted as the 5th frame.
4. Reset mid-frame: assert reset after the 5th sclk rise of a frame.
   - sclk, sdata, fsync, busy, fifo_count and overflow are all 0 immediately, without waiting for a clk edge.
   - After release with no new data, no further sclk edges occur.
5. enable dropped after bit 3 with 2 words queued: the current frame completes all 16 bits, the next frame does not start, and fifo_count=1 holds until enable returns.
6. Overflow set/clear collision: with overflow=1, a clear_ovf pulse in the same cycle as a drop leaves overflow=1. A later lone clear_ovf pulse clears it to 0.

Source files
------------

// File: rtl/decim_output_serializer_if.sv
// Bundle between the decimation filter / control logic (master) and the
// output serializer (slave): parallel word in, 3-wire serial link and status out.
interface decim_output_serializer_if #(
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] din;
  logic                 din_valid;
  logic                 enable;
  logic                 clear_ovf;
  logic                 sclk;
  logic                 sdata;
  logic                 fsync;
  logic                 busy;
  logic [CNT_W-1:0]     fifo_count;
  logic                 overflow;

  modport master (
    output din, din_valid, enable, clear_ovf,
    input  sclk, sdata, fsync, busy, fifo_count, overflow
  );

  modport slave (
    input  din, din_valid, enable, clear_ovf,
    output sclk, sdata, fsync, busy, fifo_count, overflow
  );
endinterface

// File: rtl/decim_output_serializer.sv
// Output stage of the decimation filter: captures each decimated word into a
// small FIFO and shifts it out MSB-first on sclk/sdata/fsync. Every output is
// driven straight from a flop so the serial pins never glitch.
module decim_output_serializer #(
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV        = 1
) (
  input logic                      clk,
  input logic                      reset,
  decim_output_serializer_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Holds both the half-period count (DIV) and the gap count (2*DIV).
  localparam int DIV_W = $clog2(2 * DIV);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 overflow_r;

  logic [DATA_BITS-1:0] head_s;
  logic                 full_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 drop_s;

  // Transmitter state
  state_t               state_r;
  state_t               next_state_s;
  logic [DATA_BITS-1:0] shreg_r;
  logic [DATA_BITS-1:0] shreg_s;
  logic [DIV_W-1:0]     div_cnt_r;
  logic [DIV_W-1:0]     div_cnt_s;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_s;
  logic                 sclk_r;
  logic                 sclk_s;
  logic                 sdata_r;
  logic                 sdata_s;
  logic                 fsync_r;
  logic                 fsync_s;
  logic                 busy_r;
  logic                 busy_s;

  logic                 half_tick_s;
  logic                 gap_done_s;
  logic                 last_fall_s;

  assign head_s = mem_r[rd_ptr_r];
  assign full_s = (count_r == FULL_CNT);
  // The head word leaves the FIFO at the end of the LOAD cycle.
  assign pop_s  = (state_r == LOAD);
  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  assign push_s = bus.din_valid & (~full_s | pop_s);
  assign drop_s = bus.din_valid & full_s & ~pop_s;

  assign half_tick_s = (div_cnt_r == HALF_LAST);
  assign gap_done_s  = (div_cnt_r == GAP_LAST);
  assign last_fall_s = half_tick_s & sclk_r & (bit_cnt_r == BIT_LAST);

  // FIFO write, pointer advance and registered fill level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_BITS{1'b0}};
      end
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow: a drop beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (bus.clear_ovf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.enable && (count_r != CNT_W'(0))) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        next_state_s = SHIFT;
      end
      SHIFT: begin
        if (last_fall_s) begin
          next_state_s = GAP;
        end else begin
          next_state_s = SHIFT;
        end
      end
      GAP: begin
        if (gap_done_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = GAP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM outputs: next values of the serial pins and the bit/clock dividers
  always_comb begin
    shreg_s   = shreg_r;
    div_cnt_s = div_cnt_r;
    bit_cnt_s = bit_cnt_r;
    sclk_s    = 1'b0;
    sdata_s   = 1'b0;
    fsync_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // Present the MSB and frame sync already in the LOAD cycle.
        if (next_state_s == LOAD) begin
          sdata_s = head_s[DATA_BITS-1];
          fsync_s = 1'b1;
        end else begin
          sdata_s = 1'b0;
          fsync_s = 1'b0;
        end
      end
      LOAD: begin
        shreg_s   = head_s;
        div_cnt_s = DIV_W'(0);
        bit_cnt_s = BIT_W'(0);
        sdata_s   = head_s[DATA_BITS-1];
        fsync_s   = 1'b1;
      end
      SHIFT: begin
        // The current bit always sits in the shift register MSB.
        sdata_s = shreg_r[DATA_BITS-1];
        fsync_s = fsync_r;
        sclk_s  = sclk_r;
        if (half_tick_s) begin
          div_cnt_s = DIV_W'(0);
          sclk_s    = ~sclk_r;
          if (sclk_r) begin
            // Falling edge: the receiver has taken this bit.
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
            if (last_fall_s) begin
              sdata_s = 1'b0;
              fsync_s = 1'b0;
            end else begin
              shreg_s = shreg_r << 1;
              sdata_s = shreg_r[DATA_BITS-2];
              fsync_s = 1'b0;
            end
          end else begin
            bit_cnt_s = bit_cnt_r;
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      GAP: begin
        if (gap_done_s) begin
          div_cnt_s = DIV_W'(0);
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        div_cnt_s = DIV_W'(0);
        bit_cnt_s = BIT_W'(0);
      end
    endcase
    busy_s = (next_state_s != IDLE);
  end

  // Output and datapath registers updated alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_r   <= {DATA_BITS{1'b0}};
      div_cnt_r <= DIV_W'(0);
      bit_cnt_r <= BIT_W'(0);
      sclk_r    <= 1'b0;
      sdata_r   <= 1'b0;
      fsync_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      shreg_r   <= shreg_s;
      div_cnt_r <= div_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      sclk_r    <= sclk_s;
      sdata_r   <= sdata_s;
      fsync_r   <= fsync_s;
      busy_r    <= busy_s;
    end
  end

  assign bus.sclk       = sclk_r;
  assign bus.sdata      = sdata_r;
  assign bus.fsync      = fsync_r;
  assign bus.busy       = busy_r;
  assign bus.fifo_count = count_r;
  assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_decim_output_serializer.sv
// Directed bench for decim_output_serializer with default parameters
// (16-bit words, 4-deep FIFO, DIV=1 so a frame is 35 clk cycles).
module tb_decim_output_serializer;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  decim_output_serializer_if #(.DATA_BITS(16), .FIFO_DEPTH(4)) bus_if ();

  decim_output_serializer #(
    .DATA_BITS (16),
    .FIFO_DEPTH(4),
    .DIV       (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // Serial receiver: samples sdata/fsync on each sclk rise, collects frames
  logic [15:0] frames [$];
  logic [15:0] fsyncs [$];
  int          busy_lens [$];
  logic [15:0] acc_d = 16'h0000;
  logic [15:0] acc_f = 16'h0000;
  int          nbits = 0;
  int          rise_count = 0;
  int          busy_run = 0;
  logic        sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      nbits     = 0;
      busy_run  = 0;
      sclk_prev = 1'b0;
    end else begin
      if (!sclk_prev && bus_if.sclk) begin
        acc_d = {acc_d[14:0], bus_if.sdata};
        acc_f = {acc_f[14:0], bus_if.fsync};
        nbits++;
        rise_count++;
        if (nbits == 16) begin
          frames.push_back(acc_d);
          fsyncs.push_back(acc_f);
          nbits = 0;
        end
      end
      sclk_prev = bus_if.sclk;
      if (bus_if.busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        busy_lens.push_back(busy_run);
        busy_run = 0;
      end
    end
  end

  task automatic wait_frames(input int target, input int budget, output bit to);
    int n = 0;
    while ((frames.size() < target || bus_if.busy !== 1'b0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    to = (frames.size() < target) || (bus_if.busy !== 1'b0);
    @(negedge clk); #1;
  endtask

  task automatic wait_rises(input int target, input int budget, output bit to);
    int n = 0;
    while (rise_count < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    to = (rise_count < target);
  endtask

  task automatic write_word(input logic [15:0] w);
    @(posedge clk); #1;
    bus_if.din       = w;
    bus_if.din_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.din_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus_if.sclk, bus_if.sdata, bus_if.fsync, bus_if.busy, bus_if.overflow} !== 5'b00000)
      $display("FAIL reset_outputs: got %b expected 00000",
               {bus_if.sclk, bus_if.sdata, bus_if.fsync, bus_if.busy, bus_if.overflow});
    else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus_if.fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", bus_if.fifo_count);
    else n_pass++;
  endtask

  task automatic test_single_word();
    int base;
    bit to;
    base = frames.size();
    @(posedge clk); #1;
    bus_if.enable    = 1'b1;
    bus_if.din       = 16'hA5C3;
    bus_if.din_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.din_valid = 1'b0;
    n_checks++;
    if (bus_if.fifo_count !== 3'd1) $display("FAIL t1_count_after_write: got %0d expected 1", bus_if.fifo_count);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({bus_if.busy, bus_if.fsync, bus_if.sdata, bus_if.sclk} !== 4'b1110)
      $display("FAIL t1_load_cycle: got busy/fsync/sdata/sclk=%b expected 1110",
               {bus_if.busy, bus_if.fsync, bus_if.sdata, bus_if.sclk});
    else n_pass++;
    wait_frames(base + 1, 100, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL t1_timeout: frame did not complete");
    else n_pass++;
    n_checks++;
    if (frames[base] !== 16'hA5C3) $display("FAIL t1_frame: got %h expected a5c3", frames[base]);
    else n_pass++;
    n_checks++;
    if (fsyncs[base] !== 16'h8000) $display("FAIL t1_fsync: got %h expected 8000", fsyncs[base]);
    else n_pass++;
    n_checks++;
    if (busy_lens[busy_lens.size()-1] !== 35)
      $display("FAIL t1_busy_len: got %0d expected 35", busy_lens[busy_lens.size()-1]);
    else n_pass++;
    n_checks++;
    if ({bus_if.sclk, bus_if.sdata, bus_if.fsync, bus_if.fifo_count} !== 6'b000000)
      $display("FAIL t1_idle_after: got sclk/sdata/fsync/count=%b expected 000000",
               {bus_if.sclk, bus_if.sdata, bus_if.fsync, bus_if.fifo_count});
    else n_pass++;
  endtask

  task automatic test_burst_overflow();
    int base;
    bit to;
    logic [15:0] exp_w;
    base = frames.size();
    bus_if.enable = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      bus_if.din       = 16'(i);
      bus_if.din_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus_if.din_valid = 1'b0;
    n_checks++;
    if (bus_if.fifo_count !== 3'd4) $display("FAIL t2_count_full: got %0d expected 4", bus_if.fifo_count);
    else n_pass++;
    n_checks++;
    if (bus_if.overflow !== 1'b1) $display("FAIL t2_overflow: got %b expected 1", bus_if.overflow);
    else n_pass++;
    bus_if.enable = 1'b1;
    wait_frames(base + 4, 200, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL t2_timeout: 4 frames did not complete");
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_w = 16'(i + 1);
      n_checks++;
      if (frames[base+i] !== exp_w) $display("FAIL t2_frame%0d: got %h expected %h", i, frames[base+i], exp_w);
      else n_pass++;
    end
    n_checks++;
    if (frames.size() !== base + 4) $display("FAIL t2_frame_count: got %0d expected %0d", frames.size(), base + 4);
    else n_pass++;
    n_checks++;
    if (bus_if.fifo_count !== 3'd0) $display("FAIL t2_count_drained: got %0d expected 0", bus_if.fifo_count);
    else n_pass++;
    n_checks++;
    if (bus_if.overflow !== 1'b1) $display("FAIL t2_overflow_sticky: got %b expected 1", bus_if.overflow);
    else n_pass++;
    @(posedge clk); #1;
    bus_if.clear_ovf = 1'b1;
    @(posedge clk); #1;
    bus_if.clear_ovf = 1'b0;
    n_checks++;
    if (bus_if.overflow !== 1'b0) $display("FAIL t2_overflow_clear: got %b expected 0", bus_if.overflow);
    else n_pass++;
  endtask

  task automatic test_full_pop_write();
    int base;
    bit to;
    logic [15:0] exp_w [5];
    exp_w = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h00FF};
    base = frames.size();
    bus_if.enable = 1'b0;
    for (int i = 0; i < 4; i++) write_word(exp_w[i]);
    @(posedge clk); #1;
    bus_if.enable = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus_if.busy, bus_if.fifo_count} !== 4'b1100)
      $display("FAIL t3_load_full: got busy/count=%b expected 1100", {bus_if.busy, bus_if.fifo_count});
    else n_pass++;
    bus_if.din       = 16'h00FF;
    bus_if.din_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.din_valid = 1'b0;
    n_checks++;
    if (bus_if.fifo_count !== 3'd4) $display("FAIL t3_count_hold: got %0d expected 4", bus_if.fifo_count);
    else n_pass++;
    n_checks++;
    if (bus_if.overflow !== 1'b0) $display("FAIL t3_no_overflow: got %b expected 0", bus_if.overflow);
    else n_pass++;
    wait_frames(base + 5, 250, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL t3_timeout: 5 frames did not complete");
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (frames[base+i] !== exp_w[i]) $display("FAIL t3_frame%0d: got %h expected %h", i, frames[base+i], exp_w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_enable_drop();
    int base;
    int base_r;
    bit to;
    base = frames.size();
    bus_if.enable = 1'b0;
    write_word(16'h1234);
    write_word(16'h5678);
    base_r = rise_count;
    @(posedge clk); #1;
    bus_if.enable = 1'b1;
    wait_rises(base_r + 4, 60, to);
    bus_if.enable = 1'b0;
    n_checks++;
    if (to !== 1'b0) $display("FAIL t5_rise_timeout: bit 3 never sampled");
    else n_pass++;
    wait_frames(base + 1, 100, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL t5_timeout: first frame did not complete");
    else n_pass++;
    n_checks++;
    if (frames[base] !== 16'h1234) $display("FAIL t5_frame0: got %h expected 1234", frames[base]);
    else n_pass++;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if ({bus_if.busy, bus_if.fifo_count} !== 4'b0001)
      $display("FAIL t5_held: got busy/count=%b expected 0001", {bus_if.busy, bus_if.fifo_count});
    else n_pass++;
    n_checks++;
    if (frames.size() !== base + 1) $display("FAIL t5_no_new_frame: got %0d frames expected %0d", frames.size(), base + 1);
    else n_pass++;
    bus_if.enable = 1'b1;
    wait_frames(base + 2, 100, to);
    n_checks++;
    if (frames[base+1] !== 16'h5678 || to !== 1'b0)
      $display("FAIL t5_frame1: got %h (timeout=%b) expected 5678", frames[base+1], to);
    else n_pass++;
    n_checks++;
    if (bus_if.fifo_count !== 3'd0) $display("FAIL t5_count_drained: got %0d expected 0", bus_if.fifo_count);
    else n_pass++;
  endtask

  task automatic test_overflow_collision();
    int base;
    bit to;
    base = frames.size();
    bus_if.enable = 1'b0;
    write_word(16'h0101);
    write_word(16'h0202);
    write_word(16'h0303);
    write_word(16'h0404);
    write_word(16'h0E0E);
    n_checks++;
    if (bus_if.overflow !== 1'b1) $display("FAIL t6_drop_sets: got %b expected 1", bus_if.overflow);
    else n_pass++;
    @(posedge clk); #1;
    bus_if.din       = 16'h0F0F;
    bus_if.din_valid = 1'b1;
    bus_if.clear_ovf = 1'b1;
    @(posedge clk); #1;
    bus_if.din_valid = 1'b0;
    bus_if.clear_ovf = 1'b0;
    n_checks++;
    if (bus_if.overflow !== 1'b1) $display("FAIL t6_set_wins: got %b expected 1", bus_if.overflow);
    else n_pass++;
    @(posedge clk); #1;
    bus_if.clear_ovf = 1'b1;
    @(posedge clk); #1;
    bus_if.clear_ovf = 1'b0;
    n_checks++;
    if (bus_if.overflow !== 1'b0) $display("FAIL t6_lone_clear: got %b expected 0", bus_if.overflow);
    else n_pass++;
    n_checks++;
    if (bus_if.fifo_count !== 3'd4) $display("FAIL t6_count: got %0d expected 4", bus_if.fifo_count);
    else n_pass++;
    bus_if.enable = 1'b1;
    wait_frames(base + 4, 200, to);
    n_checks++;
    if (to !== 1'b0 || frames[base] !== 16'h0101 || frames[base+3] !== 16'h0404)
      $display("FAIL t6_drain: got first %h last %h (timeout=%b) expected 0101 0404",
               frames[base], frames[base+3], to);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int base_r;
    bit to;
    bus_if.enable = 1'b0;
    write_word(16'hBEEF);
    write_word(16'hCAFE);
    base_r = rise_count;
    bus_if.enable = 1'b1;
    wait_rises(base_r + 5, 60, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL t4_rise_timeout: 5th sclk rise never seen");
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus_if.sclk, bus_if.sdata, bus_if.fsync, bus_if.busy, bus_if.overflow} !== 5'b00000)
      $display("FAIL t4_async_outputs: got sclk/sdata/fsync/busy/ovf=%b expected 00000",
               {bus_if.sclk, bus_if.sdata, bus_if.fsync, bus_if.busy, bus_if.overflow});
    else n_pass++;
    n_checks++;
    if (bus_if.fifo_count !== 3'd0) $display("FAIL t4_async_count: got %0d expected 0", bus_if.fifo_count);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    base_r = rise_count;
    repeat (60) @(posedge clk);
    #1;
    n_checks++;
    if (rise_count !== base_r) $display("FAIL t4_no_sclk: got %0d rises expected 0", rise_count - base_r);
    else n_pass++;
    n_checks++;
    if ({bus_if.busy, bus_if.fifo_count} !== 4'b0000)
      $display("FAIL t4_idle_after: got busy/count=%b expected 0000", {bus_if.busy, bus_if.fifo_count});
    else n_pass++;
  endtask

  initial begin
    bus_if.din       = 16'h0000;
    bus_if.din_valid = 1'b0;
    bus_if.enable    = 1'b0;
    bus_if.clear_ovf = 1'b0;
    test_reset();
    test_single_word();
    test_burst_overflow();
    test_full_pop_write();
    test_enable_drop();
    test_overflow_collision();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
